mult16s_rr_arbiter: RTL and testbench
=====================================

Name: mult16s_rr_arbiter

Overview:
- Shares one combinational signed 16x16 multiplier core, mult16s_normal_sklansky, between NUM_REQ requesters.
- Each requester uses a valid/ready request channel and a valid/ready response channel.
- The block does round-robin arbitration, registers operands and product around the core (2-cycle pipe), and tracks which requester owns each in-flight operation.
- Results return per requester and are held until consumed.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- IDX_W, $clog2(NUM_REQ), width of requester index / round-robin pointer.

Ports:
- clk  in  1  clock; all logic rises on posedge.
- rst_n  in  1  reset: synchronous, active-low.
- req_valid  in  NUM_REQ  per-requester operation request.
- req_ready  out  NUM_REQ  one-hot grant; accept when req_valid[i] & req_ready[i].
- req_a  in  NUM_REQ*16  packed signed multiplicands; slice i is [16*i+:16].
- req_b  in  NUM_REQ*16  packed signed multipliers.
- rsp_valid  out  NUM_REQ  result available for requester i.
- rsp_ready  in  NUM_REQ  requester i consumes its result.
- rsp_product  out  NUM_REQ*32  packed signed products; slice i is [32*i+:32].
- busy  out  NUM_REQ  requester i has an operation in flight or a result pending.

Behaviour:
- Reset (rst_n=0 at posedge):
  - req_ready=0, rsp_valid=0, rsp_product=0, busy=0.
  - RR pointer=0, pipeline valids=0.
  - Reset mid-operation discards all in-flight ops and pending results.
- Eligibility: elig[i] = req_valid[i] & ~busy[i]. At most one outstanding op per requester.
- Arbitration (combinational, same cycle):
  - Grant the first eligible index at or after ptr, scanning upward and wrapping mod NUM_REQ.
  - req_ready = one-hot grant, or zero if nothing is eligible.
  - req_ready depends combinationally on req_valid; requesters must not make req_valid depend on req_ready.
- Pointer update: on accept of index g, ptr <= (g+1) mod NUM_REQ. There is no update when nothing is accepted.
- Pipeline:
  - Cycle T (accept edge): S1 <= {a, b, tag=g, v=1}; busy[g] <= 1.
  - Cycle T+1 edge: S2 product register <= core(S1.a, S1.b); S2 carries tag and v.
  - Cycle T+2 edge: rsp_product[tag] <= S2.product; rsp_valid[tag] <= 1.
  - Result is visible 3 edges after the accept edge (latency 3 cycles accept-to-rsp_valid).
  - Throughput is one accept per cycle across requesters.
- Response hold:
  - rsp_valid[i] and rsp_product[i] stay stable until rsp_valid[i] & rsp_ready[i] at an edge.
  - At that edge rsp_valid[i] <= 0 and busy[i] <= 0.
  - rsp_product[i] retains its last value after the handshake.
- Re-issue: requester i can be granted in the cycle after its response handshake, not in the same cycle, because busy is registered.
- Simultaneous events:
  - Accept, write-back and response handshakes for different requesters in the same cycle are all honoured.
  - Write-back never collides with a pending result, because of the one-outstanding rule.
- Arithmetic:
  - Full signed 16x16 product to 32 bits with no truncation or saturation.
  - -32768 * -32768 = 0x40000000.
- Idle: S1/S2 operand and product registers may hold stale data when v=0. They must not cause rsp_valid.
- busy[i] = in-flight (S1 or S2 or write-back pending) OR rsp_valid[i].

Decomposition:
- Shared package mult_arb_pkg holds:
  - localparams OP_W=16, PROD_W=32, PIPE_LAT=3.
  - typedef op_t (a, b, tag, v).
- One natural sub-module: rr_pick, a parameterised round-robin priority picker.
  - Inputs: elig vector and ptr.
  - Outputs: one-hot grant and encoded index.
- The multiplier core is instantiated directly, unmodified.

Test Plan:
- Single op: after reset, req0 a=3, b=-5 -> req_ready[0]=1 same cycle; rsp_valid[0] rises 3 cycles later with rsp_product[0]=0xFFFFFFF1; busy[0] high throughout; cleared after rsp_ready.
- Corner values: (-32768,-32768) -> 0x40000000; (32767,-32768) -> 0xC0008000; (0,x) -> 0.
- Fairness: all 4 requesters valid continuously, each consuming rsp immediately.
  - Grants go 0,1,2,3,0,...
  - No requester is granted twice before the others are granted once.
  - Pointer wraps from 3 to 0.
- Backpressure: rsp_ready[1]=0 for 10 cycles with req_valid[1] held.
  - req_ready[1] stays 0 and rsp_product[1] stays stable.
  - Other requesters keep being served.
  - After rsp_ready[1] pulses, req1 is re-granted the next cycle.
- Reset mid-flight: accept ops on req0 and req2, then assert rst_n=0 one cycle later.
  - Next cycle all rsp_valid=0, busy=0, ptr=0.
  - No stale result appears after reset release.
- Back-to-back throughput: req0..3 accepted on 4 consecutive cycles with distinct operands.
  - Four rsp_valid rise on 4 consecutive cycles.
  - Each result is routed to the correct index with the correct product.

Source files
------------

// File: rtl/mult_arb_pkg.sv
// Shared types and constants for the round-robin arbiter wrapped around a
// single signed 16x16 multiplier.
package mult_arb_pkg;

  localparam int OP_W     = 16;
  localparam int PROD_W   = 32;
  localparam int PIPE_LAT = 3;
  // Wide enough for the largest supported requester count (8).
  localparam int TAG_W    = 3;

  typedef struct packed {
    logic signed [OP_W-1:0] a;
    logic signed [OP_W-1:0] b;
    logic [TAG_W-1:0]       tag;
    logic                   v;
  } op_t;

  typedef struct packed {
    logic signed [PROD_W-1:0] product;
    logic [TAG_W-1:0]         tag;
    logic                     v;
  } res_t;

endpackage

// File: rtl/mult16s_normal_sklansky.sv
// Combinational signed 16x16 multiplier: shift-add partial products, with the
// negatively weighted top row subtracted through a Sklansky prefix adder.
module mult16s_normal_sklansky (
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  output logic [31:0] p_o
);

  logic [31:0] aExt;
  logic [31:0] acc;
  logic [31:0] subtrahend;
  logic [31:0] gen;
  logic [31:0] prop;
  logic [31:0] grpG;
  logic [31:0] grpP;
  logic [31:0] carry;

  assign aExt = {{16{a_i[15]}}, a_i};

  // Rows 0..14 carry positive weight; row 15 is the sign row of b.
  always_comb begin
    acc = '0;
    for (int j = 0; j < 15; j++) begin
      if (b_i[j]) begin
        acc = acc + (aExt << j);
      end
    end
    subtrahend = b_i[15] ? (aExt << 15) : '0;
  end

  // acc - subtrahend as acc + ~subtrahend + 1; carry-in folded into bit 0.
  always_comb begin
    gen  = acc & ~subtrahend;
    prop = acc ^ ~subtrahend;
    grpG = gen;
    grpP = prop;
    grpG[0] = gen[0] | prop[0];
    for (int l = 0; l < 5; l++) begin
      for (int i = 0; i < 32; i++) begin
        if (((i >> l) & 1) == 1) begin
          grpG[i] = grpG[i] | (grpP[i] & grpG[((i >> l) << l) - 1]);
          grpP[i] = grpP[i] & grpP[((i >> l) << l) - 1];
        end
      end
    end
    carry = {grpG[30:0], 1'b1};
    p_o   = prop ^ carry;
  end

endmodule

// File: rtl/mult16s_rr_arbiter_rr_pick.sv
// Round-robin priority picker: first eligible index at or above the pointer,
// wrapping around.
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     elig_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     grant_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!valid_o && elig_i[(int'(ptr_i) + k) % N]) begin
        valid_o                         = 1'b1;
        grant_o[(int'(ptr_i) + k) % N] = 1'b1;
        idx_o                           = IDX_W'((int'(ptr_i) + k) % N);
      end
    end
  end

endmodule

// File: rtl/mult16s_rr_arbiter.sv
// Shares one signed multiplier among NUM_REQ valid/ready requesters with a
// two-register pipe; results are parked per requester until consumed.
module mult16s_rr_arbiter
  import mult_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*OP_W-1:0]   req_a,
  input  logic [NUM_REQ*OP_W-1:0]   req_b,
  output logic [NUM_REQ-1:0]        rsp_valid,
  input  logic [NUM_REQ-1:0]        rsp_ready,
  output logic [NUM_REQ*PROD_W-1:0] rsp_product,
  output logic [NUM_REQ-1:0]        busy
);

  if (PIPE_LAT != 3 || NUM_REQ < 2 || NUM_REQ > 8) begin : gParamCheck
    $error("mult16s_rr_arbiter: unsupported configuration");
  end

  logic [IDX_W-1:0]          ptr_q, ptr_d;
  logic [NUM_REQ-1:0]        busy_q, busy_d;
  logic [NUM_REQ-1:0]        rspValid_q, rspValid_d;
  logic [NUM_REQ*PROD_W-1:0] rspProduct_q, rspProduct_d;
  op_t                       s1_q, s1_d;
  res_t                      s2_q, s2_d;

  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] rspFire;
  logic [IDX_W-1:0]   grantIdx;
  logic               accept;
  logic [PROD_W-1:0]  coreProduct;

  // Reset gates eligibility so no grant is offered while rst_n is low.
  assign elig    = req_valid & ~busy_q & {NUM_REQ{rst_n}};
  assign rspFire = rspValid_q & rsp_ready;

  rr_pick #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .elig_i  (elig),
    .ptr_i   (ptr_q),
    .grant_o (grant),
    .idx_o   (grantIdx),
    .valid_o (accept)
  );

  mult16s_normal_sklansky u_core (
    .a_i (s1_q.a),
    .b_i (s1_q.b),
    .p_o (coreProduct)
  );

  always_comb begin
    ptr_d        = ptr_q;
    s1_d         = s1_q;
    s1_d.v       = accept;
    s2_d.product = coreProduct;
    s2_d.tag     = s1_q.tag;
    s2_d.v       = s1_q.v;
    busy_d       = (busy_q & ~rspFire) | grant;
    rspValid_d   = rspValid_q & ~rspFire;
    rspProduct_d = rspProduct_q;

    if (accept) begin
      ptr_d    = (grantIdx == IDX_W'(NUM_REQ - 1)) ? '0 : grantIdx + 1'b1;
      s1_d.tag = TAG_W'(grantIdx);
    end

    // Grant is one-hot, so at most one requester's operands are captured.
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        s1_d.a = req_a[OP_W*i +: OP_W];
        s1_d.b = req_b[OP_W*i +: OP_W];
      end
      if (s2_q.v && s2_q.tag == TAG_W'(i)) begin
        rspValid_d[i]                  = 1'b1;
        rspProduct_d[PROD_W*i +: PROD_W] = s2_q.product;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q        <= '0;
      busy_q       <= '0;
      rspValid_q   <= '0;
      rspProduct_q <= '0;
      s1_q         <= '0;
      s2_q         <= '0;
    end else begin
      ptr_q        <= ptr_d;
      busy_q       <= busy_d;
      rspValid_q   <= rspValid_d;
      rspProduct_q <= rspProduct_d;
      s1_q         <= s1_d;
      s2_q         <= s2_d;
    end
  end

  assign req_ready   = grant;
  assign rsp_valid   = rspValid_q;
  assign rsp_product = rspProduct_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_mult16s_rr_arbiter.sv
// Directed testbench for mult16s_rr_arbiter with hand-computed products and
// grant sequences.
module tb_mult16s_rr_arbiter;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*16-1:0] req_a;
  logic [N*16-1:0] req_b;
  logic [N-1:0]   rsp_valid;
  logic [N-1:0]   rsp_ready;
  logic [N*32-1:0] rsp_product;
  logic [N-1:0]   busy;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  mult16s_rr_arbiter #(.NUM_REQ(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_product (rsp_product),
    .busy        (busy)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int idx, input logic [15:0] a, input logic [15:0] b);
    req_valid[idx]     = 1'b1;
    req_a[16*idx +: 16] = a;
    req_b[16*idx +: 16] = b;
  endtask

  // One isolated operation: grant, latency, product, hold and release.
  task automatic runOne(input int idx, input logic [15:0] a, input logic [15:0] b,
                        input logic [31:0] expP);
    int lat;
    applyStimulus(idx, a, b);
    #1;
    checkOutput("one_grant", 32'(req_ready), 32'(1 << idx));
    tick;
    req_valid[idx] = 1'b0;
    checkOutput("one_busy", 32'(busy), 32'(1 << idx));
    lat = 1;
    while (!rsp_valid[idx] && lat < 10) begin
      tick;
      lat++;
    end
    checkOutput("one_latency", 32'(lat), 32'd3);
    checkOutput("one_product", rsp_product[32*idx +: 32], expP);
    tick;
    checkOutput("one_hold", 32'(rsp_valid), 32'(1 << idx));
    checkOutput("one_hold_busy", 32'(busy), 32'(1 << idx));
    rsp_ready[idx] = 1'b1;
    tick;
    rsp_ready[idx] = 1'b0;
    checkOutput("one_release", {24'd0, rsp_valid, busy}, 32'd0);
    checkOutput("one_retained", rsp_product[32*idx +: 32], expP);
  endtask

  logic [15:0] bA [4];
  logic [15:0] bB [4];
  logic [31:0] bP [4];
  int          othersGranted;
  logic [31:0] expV;

  initial begin
    bA[0] = 16'd1000;  bB[0] = 16'd2000;  bP[0] = 32'h001E8480;
    bA[1] = -16'sd1234; bB[1] = 16'd567;  bP[1] = 32'hFFF552E2;
    bA[2] = 16'h8000;  bB[2] = 16'd1;     bP[2] = 32'hFFFF8000;
    bA[3] = 16'd12345; bB[3] = 16'hFFFF;  bP[3] = 32'hFFFFCFC7;

    // Reset with requests pending: nothing may be granted.
    rst_n     = 1'b0;
    req_valid = '1;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = '0;
    tick;
    tick;
    checkOutput("rst_ready", 32'(req_ready), 32'd0);
    checkOutput("rst_rspv", 32'(rsp_valid), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_prod", {31'd0, |rsp_product}, 32'd0);
    req_valid = '0;
    rst_n     = 1'b1;
    tick;

    runOne(0, 16'd3, -16'sd5, 32'hFFFFFFF1);
    runOne(0, 16'h8000, 16'h8000, 32'h40000000);
    runOne(1, 16'h7FFF, 16'h8000, 32'hC0008000);
    runOne(2, 16'h0000, 16'h1234, 32'h00000000);
    runOne(3, 16'hFFFF, 16'hFFFF, 32'h00000001);

    // Fairness: pointer is back at 0, all requesters saturate.
    rsp_ready = '1;
    for (int i = 0; i < N; i++) applyStimulus(i, 16'(i + 1), 16'd2);
    for (int k = 0; k < 8; k++) begin
      #1;
      checkOutput("fair_grant", 32'(req_ready), 32'(1 << (k % 4)));
      tick;
    end
    req_valid = '0;
    repeat (6) tick;
    checkOutput("fair_drain", {24'd0, rsp_valid, busy}, 32'd0);

    // Backpressure on requester 1.
    rsp_ready = 4'b1101;
    applyStimulus(1, 16'd100, -16'sd7);
    #1;
    checkOutput("bp_first_grant", 32'(req_ready), 32'h2);
    tick;
    tick;
    tick;
    checkOutput("bp_rspv1", {31'd0, rsp_valid[1]}, 32'd1);
    checkOutput("bp_prod1", rsp_product[63:32], 32'hFFFFFD44);
    applyStimulus(0, 16'd5, 16'd5);
    applyStimulus(2, 16'd6, 16'd6);
    applyStimulus(3, 16'd7, 16'd7);
    othersGranted = 0;
    for (int c = 0; c < 10; c++) begin
      #1;
      checkOutput("bp_ready1", {31'd0, req_ready[1]}, 32'd0);
      checkOutput("bp_stable1", rsp_product[63:32], 32'hFFFFFD44);
      if ((req_ready & 4'b1101) != 4'b0000) othersGranted++;
      tick;
    end
    checkOutput("bp_others", 32'(othersGranted), 32'd8);
    checkOutput("bp_still_valid", {31'd0, rsp_valid[1]}, 32'd1);
    req_valid = 4'b0010;
    applyStimulus(1, -16'sd200, -16'sd300);
    rsp_ready = 4'b1111;
    #1;
    checkOutput("bp_pulse_ready", 32'(req_ready), 32'd0);
    tick;
    rsp_ready = 4'b1101;
    #1;
    checkOutput("bp_regrant", 32'(req_ready), 32'h2);
    tick;
    req_valid = '0;
    rsp_ready = 4'b1111;
    tick;
    tick;
    checkOutput("bp_new_rspv1", {31'd0, rsp_valid[1]}, 32'd1);
    checkOutput("bp_new_prod1", rsp_product[63:32], 32'h0000EA60);
    repeat (6) tick;

    // Reset while ops for 2 and 0 are in the pipe.
    req_valid = '0;
    applyStimulus(0, 16'd9, 16'd9);
    applyStimulus(2, 16'd8, 16'd8);
    #1;
    checkOutput("mid_grant2", 32'(req_ready), 32'h4);
    tick;
    #1;
    checkOutput("mid_grant0", 32'(req_ready), 32'h1);
    tick;
    req_valid = '0;
    rst_n     = 1'b0;
    tick;
    checkOutput("mid_rst_rspv", 32'(rsp_valid), 32'd0);
    checkOutput("mid_rst_busy", 32'(busy), 32'd0);
    checkOutput("mid_rst_prod", {31'd0, |rsp_product}, 32'd0);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick;
      checkOutput("mid_no_stale", 32'(rsp_valid), 32'd0);
    end
    req_valid = '1;
    #1;
    checkOutput("mid_ptr_zero", 32'(req_ready), 32'h1);
    req_valid = '0;

    // Back-to-back accepts on four consecutive cycles.
    rsp_ready = '1;
    for (int k = 0; k < 7; k++) begin
      req_valid = '0;
      if (k < 4) applyStimulus(k, bA[k], bB[k]);
      #1;
      if (k < 4) checkOutput("b2b_grant", 32'(req_ready), 32'(1 << k));
      tick;
      expV = (k >= 2 && k < 6) ? 32'(1 << (k - 2)) : 32'd0;
      checkOutput("b2b_rspv", 32'(rsp_valid), expV);
      if (k >= 2 && k < 6) checkOutput("b2b_prod", rsp_product[32*(k-2) +: 32], bP[k-2]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
